// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input line and received-byte outputs of the UART receiver.
interface uart_rx_if;
  logic       rx_in;        // asynchronous serial line, idle high
  logic [7:0] dout;         // last received byte
  logic       busy;         // frame reception in progress
  logic       data_strobe;  // one-cycle pulse when dout/rx_error update
  logic       rx_error;     // parity or stop-bit error on the last frame

  // Line driver side (board pin model / testbench)
  modport master (
    output rx_in,
    input  dout,
    input  busy,
    input  data_strobe,
    input  rx_error
  );

  // Receiver side
  modport slave (
    input  rx_in,
    output dout,
    output busy,
    output data_strobe,
    output rx_error
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8-bit, parity, one-stop-bit UART receiver. The line is synchronized,
// a falling edge starts a frame, and every bit is sampled at its midpoint.
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY        = 1  // 1 = odd, 0 = even
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BIT    = BAUD_CLOCKS / 2;
  localparam int CNT_W       = (BAUD_CLOCKS > 2) ? $clog2(BAUD_CLOCKS) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CLOCKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic             PAR_BIT   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Synchronizer and edge-detect flops; all reset high so reset looks like an idle line.
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_s_d_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             par_err_q;
  logic [7:0]       dout_q;
  logic             busy_q;
  logic             strobe_q;
  logic             err_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_s_d_q  <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx_in;
      rx_s_q    <= rx_meta_q;
      rx_s_d_q  <= rx_s_q;
    end
  end

  // Frame FSM with bit timing counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          // Only a genuine high-to-low transition starts a frame, so a line
          // still low after a framing error cannot retrigger.
          if (rx_s_d_q && !rx_s_q) begin
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          busy_q <= 1'b1;
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              // Line back high at mid start bit: glitch, not a frame.
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              idx_q   <= '0;
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == BAUD_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};  // LSB first on the line
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == BAUD_LAST) begin
            cnt_q     <= '0;
            par_err_q <= (^shift_q) ^ rx_s_q ^ PAR_BIT;
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == BAUD_LAST) begin
            // Return to IDLE at the stop-bit midpoint so an immediately
            // following start bit is still caught.
            cnt_q    <= '0;
            dout_q   <= shift_q;
            err_q    <= par_err_q | ~rx_s_q;
            strobe_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dout        = dout_q;
  assign bus.busy        = busy_q;
  assign bus.data_strobe = strobe_q;
  assign bus.rx_error    = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx, run at a fast baud rate
// (50 clocks per bit) so the whole sequence stays short.
module tb_uart_rx;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 2_000_000;
  localparam int BC       = CLK_FREQ / BAUD;  // 50
  localparam int HB       = BC / 2;           // 25

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if bus();

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQUENCY(CLK_FREQ),
    .BAUD_RATE    (BAUD),
    .PARITY       (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         t;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   strobe_count = 0;
  logic strobe_prev  = 1'b0;
  logic busy_mid     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every strobe is matched against the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (bus.data_strobe === 1'b1) begin
      strobe_count++;
      tests_run++;
      if (strobe_prev === 1'b1) begin
        tests_failed++;
        $display("FAIL strobe_single: strobe high two cycles running at cyc %0d, required single pulse", cyc);
      end
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_strobe: dout=%h err=%b at cyc %0d, required no strobe", bus.dout, bus.rx_error, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.dout !== e.data || bus.rx_error !== e.err || cyc < e.t - 1 || cyc > e.t + 1) begin
          tests_failed++;
          $display("FAIL frame: got dout=%h err=%b cyc=%0d, required dout=%h err=%b cyc=%0d", bus.dout, bus.rx_error, cyc, e.data, e.err, e.t);
        end else begin
          $display("[TB] frame dout=%h err=%b cyc=%0d ok", bus.dout, bus.rx_error, cyc);
        end
      end
    end
    strobe_prev = bus.data_strobe;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // Drive one frame starting at the current negedge; expectation pushed at start.
  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_bit,
                            input logic exp_err);
    logic [10:0] frame;
    exp_t e;
    frame  = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
    e.data = b;
    e.err  = exp_err;
    e.t    = cyc + 3 + HB + 10 * BC;
    sb.push_back(e);
    for (int i = 0; i < 11; i++) begin
      bus.rx_in = frame[i];
      repeat (BC) @(negedge clk);
      if (i == 0) busy_mid = bus.busy;
    end
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3 * BC && sb.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d frames outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.rx_in = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #10;
      bus.rx_in = ~bus.rx_in;
      tests_run++;
      if (bus.dout !== 8'h00 || bus.busy !== 1'b0 || bus.data_strobe !== 1'b0 || bus.rx_error !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_values: dout=%h busy=%b strobe=%b err=%b, required 00 0 0 0",
                 bus.dout, bus.busy, bus.data_strobe, bus.rx_error);
      end
    end
    @(negedge clk);
    bus.rx_in = 1'b1;
    rst = 1'b0;
    repeat (10000) @(negedge clk);
    tests_run++;
    if (strobe_count != 0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: strobes=%0d busy=%b, required 0 0", strobe_count, bus.busy);
    end
  endtask

  task automatic test_clean();
    logic [7:0] bytes [6];
    bytes[0] = 8'hA5;
    bytes[1] = 8'h00;
    bytes[2] = 8'hFF;
    for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      send_frame(bytes[i], 1'b0, 1'b1, 1'b0);
      tests_run++;
      if (busy_mid !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_mid_frame: busy=%b after start bit, required 1", busy_mid);
      end
      idle(20);
      wait_drain();
      tests_run++;
      if (bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL busy_after_frame: busy=%b, required 0", bus.busy);
      end
    end
  endtask

  task automatic test_parity_error();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle(3 * BC);
    wait_drain();
    tests_run++;
    if (bus.dout !== 8'h3C || bus.rx_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_hold: dout=%h err=%b, required 3c 1", bus.dout, bus.rx_error);
    end
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    idle(20);
    wait_drain();
  endtask

  task automatic test_framing_error();
    int base;
    base = strobe_count;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    repeat (2 * BC) @(negedge clk);
    idle(4 * BC);
    wait_drain();
    tests_run++;
    if (strobe_count - base != 1 || bus.busy !== 1'b0 || bus.rx_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL framing: strobes=%0d busy=%b err=%b, required 1 0 1", strobe_count - base, bus.busy, bus.rx_error);
    end
  endtask

  task automatic test_false_start();
    int   base;
    logic busy_seen;
    base      = strobe_count;
    busy_seen = 1'b0;
    bus.rx_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      busy_seen |= bus.busy;
    end
    bus.rx_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      busy_seen |= bus.busy;
    end
    tests_run++;
    if (busy_seen !== 1'b1 || bus.busy !== 1'b0 || strobe_count != base) begin
      tests_failed++;
      $display("FAIL false_start: busy_seen=%b busy=%b strobes=%0d, required 1 0 0", busy_seen, bus.busy, strobe_count - base);
    end
    idle(BC);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    idle(20);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int base;
    base = strobe_count;
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    idle(20);
    wait_drain();
    tests_run++;
    if (strobe_count - base != 2) begin
      tests_failed++;
      $display("FAIL back_to_back: strobes=%0d, required 2", strobe_count - base);
    end
  endtask

  task automatic test_mid_reset();
    logic [9:0] bits;
    int         base;
    base = strobe_count;
    bits = {(~^8'hF0), 8'hF0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.rx_in = bits[i];
      repeat (BC) @(negedge clk);
    end
    bus.rx_in = bits[5];  // data bit 4
    repeat (HB) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_before_reset: busy=%b, required 1", bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.data_strobe !== 1'b0 || bus.dout !== 8'h00 || bus.rx_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: busy=%b strobe=%b dout=%h err=%b, required 0 0 00 0",
               bus.busy, bus.data_strobe, bus.dout, bus.rx_error);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(12 * BC);
    tests_run++;
    if (strobe_count != base || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_mid_reset: strobes=%0d busy=%b, required 0 0", strobe_count - base, bus.busy);
    end
  endtask

  initial begin
    bus.rx_in = 1'b1;
    test_reset();
    test_clean();
    test_parity_error();
    test_framing_error();
    test_false_start();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
